// File: rtl/sequencer.sv
// Control sequencer for the basic processor.
// Fetches each instruction over sysbus through the shared MAR/MDR memory
// protocol, then drives the PC, IR, ACC, ALU and memory strobes needed to
// execute it. Also counts retired instructions.
// Strobes are a Moore decode of the state register (plus op / z_flag in the
// states that inspect them). While reset is high every output reads 0.
module sequencer #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             z_flag,
    output logic             PC_bus,
    output logic             load_PC,
    output logic             INC_PC,
    output logic             load_IR,
    output logic             Addr_bus,
    output logic             load_MAR,
    output logic             MDR_bus,
    output logic             load_MDR,
    output logic             CS,
    output logic             R_NW,
    output logic             ACC_bus,
    output logic             load_ACC,
    output logic [2:0]       ALU_op,
    output logic             fetching,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    // The opcode field must leave room for an address field in the word.
    if (OP_W >= WORD_W) begin : g_bad_width
        $error("sequencer: OP_W must be narrower than WORD_W");
    end

    // Opcode encodings of the instruction set.
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_COMP  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

    // ALU function codes.
    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_XOR  = 3'd3;
    localparam logic [2:0] ALU_COMP = 3'd4;

    typedef enum logic [3:0] {
        FETCH_A = 4'd0,
        FETCH_M = 4'd1,
        FETCH_I = 4'd2,
        DECODE  = 4'd3,
        OPER_M  = 4'd4,
        OPER_X  = 4'd5,
        STORE_D = 4'd6,
        STORE_M = 4'd7,
        HALT_ST = 4'd8
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             retire;

    // State transitions and retired-instruction counter (wraps silently).
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH_A;
            cnt   <= '0;
        end else begin
            if (retire) begin
                cnt <= cnt + CNT_W'(1);
            end
            case (state)
                FETCH_A: state <= FETCH_M;
                FETCH_M: state <= FETCH_I;
                FETCH_I: state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LOAD, OP_ADD, OP_SUB, OP_XOR: state <= OPER_M;
                        OP_STORE:                        state <= STORE_D;
                        OP_HALT:                         state <= HALT_ST;
                        default:                         state <= FETCH_A;
                    endcase
                end
                OPER_M:  state <= OPER_X;
                OPER_X:  state <= FETCH_A;
                STORE_D: state <= STORE_M;
                STORE_M: state <= FETCH_A;
                HALT_ST: state <= HALT_ST;
                // Any corrupted encoding restarts at an instruction fetch.
                default: state <= FETCH_A;
            endcase
        end
    end

    // Strobe decode from the current state; reset masks everything to 0.
    always_comb begin
        PC_bus   = 1'b0;
        load_PC  = 1'b0;
        INC_PC   = 1'b0;
        load_IR  = 1'b0;
        Addr_bus = 1'b0;
        load_MAR = 1'b0;
        MDR_bus  = 1'b0;
        load_MDR = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b0;
        ACC_bus  = 1'b0;
        load_ACC = 1'b0;
        ALU_op   = ALU_PASS;
        fetching = 1'b0;
        halted   = 1'b0;
        retire   = 1'b0;
        case (state)
            FETCH_A: begin
                PC_bus   = 1'b1;
                load_MAR = 1'b1;
                load_PC  = 1'b1;
                INC_PC   = 1'b1;
                fetching = 1'b1;
            end
            FETCH_M: begin
                CS       = 1'b1;
                R_NW     = 1'b1;
                fetching = 1'b1;
            end
            FETCH_I: begin
                MDR_bus  = 1'b1;
                load_IR  = 1'b1;
                fetching = 1'b1;
            end
            DECODE: begin
                case (op)
                    OP_LOAD, OP_ADD, OP_SUB, OP_XOR, OP_STORE: begin
                        Addr_bus = 1'b1;
                        load_MAR = 1'b1;
                    end
                    OP_COMP: begin
                        ALU_op   = ALU_COMP;
                        load_ACC = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_BNE: begin
                        // Branch taken only when the last result was non-zero.
                        Addr_bus = ~z_flag;
                        load_PC  = ~z_flag;
                        retire   = 1'b1;
                    end
                    default: begin
                        // HALT and any unassigned code retire with no strobes.
                        retire = 1'b1;
                    end
                endcase
            end
            OPER_M: begin
                CS   = 1'b1;
                R_NW = 1'b1;
            end
            OPER_X: begin
                MDR_bus  = 1'b1;
                load_ACC = 1'b1;
                retire   = 1'b1;
                case (op)
                    OP_ADD:  ALU_op = ALU_ADD;
                    OP_SUB:  ALU_op = ALU_SUB;
                    OP_XOR:  ALU_op = ALU_XOR;
                    default: ALU_op = ALU_PASS;
                endcase
            end
            STORE_D: begin
                ACC_bus  = 1'b1;
                load_MDR = 1'b1;
            end
            STORE_M: begin
                CS     = 1'b1;
                R_NW   = 1'b0;
                retire = 1'b1;
            end
            HALT_ST: begin
                halted = 1'b1;
            end
            default: begin
                retire = 1'b0;
            end
        endcase
        if (reset) begin
            PC_bus   = 1'b0;
            load_PC  = 1'b0;
            INC_PC   = 1'b0;
            load_IR  = 1'b0;
            Addr_bus = 1'b0;
            load_MAR = 1'b0;
            MDR_bus  = 1'b0;
            load_MDR = 1'b0;
            CS       = 1'b0;
            R_NW     = 1'b0;
            ACC_bus  = 1'b0;
            load_ACC = 1'b0;
            ALU_op   = ALU_PASS;
            fetching = 1'b0;
            halted   = 1'b0;
            retire   = 1'b0;
        end
    end

    assign instr_cnt = reset ? '0 : cnt;

endmodule
